// File: rtl/pl_fifo_stage_pkg.sv
// Pipeline-protocol constants shared by every pipeline stage and bench.
package pl_fifo_stage_pkg;
  localparam int PL_WIDTH    = 17;
  localparam int PL_LAST_BIT = 16;

  function automatic int pl_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pl_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
module pl_fifo_mem #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Entries carry no reset; validity is tracked by the stage's level counter.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/pl_fifo_stage.sv
// Skid-free FIFO pipeline stage with registered valid/stall flags and flush.
module pl_fifo_stage
  import pl_fifo_stage_pkg::*;
#(
  parameter int WIDTH = PL_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   stall_out,
  output logic                   valid_out,
  output logic [WIDTH-1:0]       data_out,
  input  logic                   stall_in,
  input  logic                   annul_in,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;
  logic [WIDTH-1:0] rd_data;

  // Flags come purely from the registered level so neighbours see no comb path.
  assign valid_out = (level != '0);
  assign stall_out = (level == LW'(DEPTH));

  assign push = valid_in  && !stall_out && !annul_in;
  assign pop  = valid_out && !stall_in  && !annul_in;

  always_ff @(posedge clk) begin
    if (reset || annul_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  pl_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Empty reads would expose unreset storage; force a clean zero instead.
  assign data_out = valid_out ? rd_data : '0;
endmodule

// File: tb/tb_pl_fifo_stage.sv
// Directed vector table plus wrap and random-stream scoreboard for pl_fifo_stage.
module tb_pl_fifo_stage;
  import pl_fifo_stage_pkg::*;

  localparam int WIDTH = PL_WIDTH;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset, valid_in, stall_in, annul_in;
  logic [WIDTH-1:0] data_in;
  logic             stall_out, valid_out;
  logic [WIDTH-1:0] data_out;
  logic [2:0]       level;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  pl_fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .stall_out (stall_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .stall_in  (stall_in),
    .annul_in  (annul_in),
    .level     (level)
  );

  typedef struct {
    logic             rst, vin, sin, ann;
    logic [WIDTH-1:0] din;
    logic             e_vout, e_sout;
    logic [2:0]       e_lvl;
    logic [WIDTH-1:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, vin, sin, ann, input logic [WIDTH-1:0] din,
                              input logic ev, es, input logic [2:0] el,
                              input logic [WIDTH-1:0] ed);
    vec_t v;
    v.rst = rst; v.vin = vin; v.sin = sin; v.ann = ann; v.din = din;
    v.e_vout = ev; v.e_sout = es; v.e_lvl = el; v.e_dout = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, vin, sin, ann, input logic [WIDTH-1:0] din);
    reset = rst; valid_in = vin; stall_in = sin; annul_in = ann; data_in = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_d;
    int  sent, cyc;
    bit  got_last, do_push, do_pop;

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step();

    // rst vin sin ann din | vout sout lvl dout
    vecs.push_back(mk(1,0,0,0,17'h0,      0,0,3'd0,17'h0));      // reset state
    vecs.push_back(mk(0,1,1,0,17'h00001,  1,0,3'd1,17'h00001));  // fill under stall
    vecs.push_back(mk(0,1,1,0,17'h00002,  1,0,3'd2,17'h00001));
    vecs.push_back(mk(0,1,1,0,17'h00003,  1,0,3'd3,17'h00001));
    vecs.push_back(mk(0,1,1,0,17'h00004,  1,1,3'd4,17'h00001));  // full
    vecs.push_back(mk(0,1,1,0,17'h00005,  1,1,3'd4,17'h00001));  // 5th held upstream
    vecs.push_back(mk(0,1,0,0,17'h00005,  1,0,3'd3,17'h00002));  // full+pop: no push
    vecs.push_back(mk(0,1,0,0,17'h00005,  1,0,3'd3,17'h00003));  // push+pop together
    vecs.push_back(mk(0,0,0,0,17'h0,      1,0,3'd2,17'h00004));
    vecs.push_back(mk(0,0,0,0,17'h0,      1,0,3'd1,17'h00005));
    vecs.push_back(mk(0,0,0,0,17'h0,      0,0,3'd0,17'h0));      // drained
    vecs.push_back(mk(0,1,1,0,17'h00100,  1,0,3'd1,17'h00100));
    vecs.push_back(mk(0,1,1,0,17'h00101,  1,0,3'd2,17'h00100));
    vecs.push_back(mk(0,1,1,0,17'h00102,  1,0,3'd3,17'h00100));
    vecs.push_back(mk(0,1,0,1,17'h0BEEF,  0,0,3'd0,17'h0));      // annul beats push/pop
    vecs.push_back(mk(0,0,0,0,17'h0,      0,0,3'd0,17'h0));      // 0xBEEF never shows
    vecs.push_back(mk(0,1,1,0,17'h1ABCD,  1,0,3'd1,17'h1ABCD));  // last flag carried
    vecs.push_back(mk(0,1,1,0,17'h00022,  1,0,3'd2,17'h1ABCD));
    vecs.push_back(mk(1,1,0,1,17'h00033,  0,0,3'd0,17'h0));      // reset mid-stream
    vecs.push_back(mk(0,0,0,0,17'h0,      0,0,3'd0,17'h0));
    vecs.push_back(mk(0,1,1,0,17'h00044,  1,0,3'd1,17'h00044));  // reset beat not kept
    vecs.push_back(mk(0,0,0,0,17'h0,      0,0,3'd0,17'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vin, vecs[i].sin, vecs[i].ann, vecs[i].din);
      step();
      chk($sformatf("vec%0d.valid_out", i), 32'(valid_out), 32'(vecs[i].e_vout));
      chk($sformatf("vec%0d.stall_out", i), 32'(stall_out), 32'(vecs[i].e_sout));
      chk($sformatf("vec%0d.level",     i), 32'(level),     32'(vecs[i].e_lvl));
      chk($sformatf("vec%0d.data_out",  i), 32'(data_out),  32'(vecs[i].e_dout));
    end

    // Wrap: ten single-beat push/pop pairs carry both pointers around twice.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, WIDTH'(17'h0A00 + i));
      step();
      chk($sformatf("wrap%0d.data_out", i), 32'(data_out), 32'h0A00 + i);
      chk($sformatf("wrap%0d.level", i), 32'(level), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      step();
      chk($sformatf("wrap%0d.empty", i), 32'(valid_out), 32'd0);
    end

    // Random stream against a queue model; last flag marks the final beat.
    sent = 0; cyc = 0; got_last = 0;
    while (!got_last && cyc < 40000) begin
      drive(1'b0, (sent < 3000) && ($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
            1'b0, {(sent == 2999), 16'($urandom)});
      #1;
      do_push = valid_in && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && !stall_in;
      if (level != 3'(q.size()) || stall_out != (q.size() == DEPTH))
        chk("stream.flags", {level, stall_out}, {3'(q.size()), q.size() == DEPTH});
      if (do_pop) begin
        exp_d = q.pop_front();
        chk("stream.data", 32'(data_out), 32'(exp_d));
        if (exp_d[PL_LAST_BIT]) got_last = 1;
      end
      if (do_push) begin
        q.push_back(data_in);
        sent++;
      end
      step();
      cyc++;
    end
    chk("stream.last_seen", 32'(got_last), 32'd1);
    chk("stream.all_sent", sent, 3000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
